// File: rtl/sram_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : sram_program_loader
// Purpose  : Receives a program over 8N1 UART, packs byte pairs into 16-bit
//            words and writes them to the CPU's instruction SRAM at BASE_ADDR.
// Revision : 1.0
// ============================================================================
module sram_program_loader #(
    parameter int          CLK_HZ    = 50000000,
    parameter int          BAUD      = 115200,
    parameter logic [17:0] BASE_ADDR = 18'h0FF00,
    parameter int          MAX_WORDS = 256,
    parameter int          WE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        UART_RXD,
    input  logic        START,
    output logic        SRAM_WE,
    output logic        SRAM_CE,
    output logic        SRAM_OE,
    output logic        SRAM_LB,
    output logic        SRAM_UB,
    output logic [17:0] SRAM_A,
    output logic [15:0] SRAM_DQ_O,
    output logic        SRAM_DQ_OE,
    output logic        CPU_HOLD,
    output logic        LOAD_DONE,
    output logic        LOAD_ERR,
    output logic [15:0] WORD_COUNT
);

    localparam int             DIV       = CLK_HZ / BAUD;
    localparam int             CW        = $clog2(DIV + 1);
    localparam logic [CW-1:0]  DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(DIV / 2 - 1);
    localparam int             WCW       = $clog2(WE_CYCLES + 1);
    localparam logic [WCW-1:0] WE_LAST   = WCW'(WE_CYCLES - 1);
    localparam logic [15:0]    MAX_W     = 16'(MAX_WORDS);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_W_SETUP = 3'd2;
    localparam logic [2:0] S_W_PULSE = 3'd3;
    localparam logic [2:0] S_W_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERROR   = 3'd6;

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    logic          rxd_s1_q, rxd_s2_q;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_ferr_q, rx_ferr_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rxd_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                // Half-bit recheck rejects short low glitches on the idle line
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_valid_d = rxd_s2_q;
                    rx_ferr_d  = !rxd_s2_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rxd_s1_q   <= UART_RXD;
            rxd_s2_q   <= rxd_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    logic [2:0]     state_q, state_d;
    logic [17:0]    addr_q, addr_d;
    logic [15:0]    data_q, data_d;
    logic [15:0]    word_count_q, word_count_d;
    logic           ptr_low_q, ptr_low_d;
    logic           hold_valid_q, hold_valid_d;
    logic [7:0]     hold_byte_q, hold_byte_d;
    logic [WCW-1:0] we_cnt_q, we_cnt_d;
    logic           load_done_q, load_done_d;
    logic           load_err_q, load_err_d;
    logic           w_writing;
    logic [7:0]     w_byte;
    logic [15:0]    w_count_inc;

    assign w_writing   = (state_q == S_W_SETUP) || (state_q == S_W_PULSE) ||
                         (state_q == S_W_HOLD);
    assign w_byte      = hold_valid_q ? hold_byte_q : rx_shift_q;
    assign w_count_inc = word_count_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        word_count_d = word_count_q;
        ptr_low_d    = ptr_low_q;
        hold_valid_d = hold_valid_q;
        hold_byte_d  = hold_byte_q;
        we_cnt_d     = we_cnt_q;
        load_done_d  = load_done_q;
        load_err_d   = load_err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                hold_valid_d = 1'b0;
                if (START) begin
                    state_d      = S_ARMED;
                    addr_d       = BASE_ADDR;
                    word_count_d = '0;
                    load_done_d  = 1'b0;
                    load_err_d   = 1'b0;
                    ptr_low_d    = 1'b0;
                end
            end
            S_ARMED: begin
                if (rx_ferr_q) begin
                    state_d    = S_ERROR;
                    load_err_d = 1'b1;
                end else if (hold_valid_q || rx_valid_q) begin
                    // A fresh byte arriving while the held one drains takes its slot
                    hold_valid_d = hold_valid_q && rx_valid_q;
                    if (hold_valid_q && rx_valid_q) begin
                        hold_byte_d = rx_shift_q;
                    end
                    if (ptr_low_q) begin
                        data_d[7:0] = w_byte;
                        ptr_low_d   = 1'b0;
                        we_cnt_d    = '0;
                        state_d     = S_W_SETUP;
                    end else begin
                        data_d[15:8] = w_byte;
                        ptr_low_d    = 1'b1;
                    end
                end
            end
            S_W_SETUP: state_d = S_W_PULSE;
            S_W_PULSE: begin
                if (we_cnt_q == WE_LAST) begin
                    state_d = S_W_HOLD;
                end else begin
                    we_cnt_d = we_cnt_q + WCW'(1);
                end
            end
            S_W_HOLD: begin
                word_count_d = w_count_inc;
                if (data_q[15:12] == 4'h0) begin
                    state_d     = S_DONE;
                    load_done_d = 1'b1;
                end else if (w_count_inc == MAX_W) begin
                    state_d    = S_ERROR;
                    load_err_d = 1'b1;
                end else begin
                    addr_d  = addr_q + 18'd1;
                    state_d = S_ARMED;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_writing) begin
            if (rx_ferr_q || (rx_valid_q && hold_valid_q)) begin
                state_d     = S_ERROR;
                load_err_d  = 1'b1;
                load_done_d = load_done_q;
            end else if (rx_valid_q) begin
                hold_valid_d = 1'b1;
                hold_byte_d  = rx_shift_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            addr_q       <= BASE_ADDR;
            data_q       <= '0;
            word_count_q <= '0;
            ptr_low_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_byte_q  <= '0;
            we_cnt_q     <= '0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            word_count_q <= word_count_d;
            ptr_low_q    <= ptr_low_d;
            hold_valid_q <= hold_valid_d;
            hold_byte_q  <= hold_byte_d;
            we_cnt_q     <= we_cnt_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign SRAM_CE    = 1'b0;
    assign SRAM_LB    = 1'b0;
    assign SRAM_UB    = 1'b0;
    assign SRAM_WE    = (state_q != S_W_PULSE);
    assign SRAM_OE    = w_writing;
    assign SRAM_DQ_OE = w_writing;
    assign SRAM_A     = addr_q;
    assign SRAM_DQ_O  = data_q;
    assign CPU_HOLD   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign LOAD_DONE  = load_done_q;
    assign LOAD_ERR   = load_err_q;
    assign WORD_COUNT = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_program_loader
// Purpose  : Randomized bench for sram_program_loader with a word-level model;
//            two instances (MAX_WORDS 256 and 2) share the same stimulus.
// Revision : 1.0
// ============================================================================
module tb_sram_program_loader;

    localparam int          DIV  = 16;
    localparam logic [17:0] BASE = 18'h0FF00;
    localparam int          WEC  = 2;

    typedef struct packed {
        logic [17:0] a;
        logic [15:0] d;
        logic [31:0] len;
        logic        stable;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic start = 1'b0;

    logic        we_n [2];
    logic        ce_n [2];
    logic        oe_n [2];
    logic        lb_n [2];
    logic        ub_n [2];
    logic [17:0] sa   [2];
    logic [15:0] dq   [2];
    logic        dq_oe[2];
    logic        hold [2];
    logic        ld   [2];
    logic        le   [2];
    logic [15:0] wcnt [2];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  sent_q[$];
    wr_t         mon0[$];
    wr_t         mon1[$];
    logic [31:0] lowcnt[2];
    wr_t         cap[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_program_loader #(
            .CLK_HZ   (1600),
            .BAUD     (100),
            .BASE_ADDR(18'h0FF00),
            .MAX_WORDS((g == 0) ? 256 : 2),
            .WE_CYCLES(2)
        ) u_dut (
            .CLK       (clk),
            .RST       (rst),
            .UART_RXD  (rxd),
            .START     (start),
            .SRAM_WE   (we_n[g]),
            .SRAM_CE   (ce_n[g]),
            .SRAM_OE   (oe_n[g]),
            .SRAM_LB   (lb_n[g]),
            .SRAM_UB   (ub_n[g]),
            .SRAM_A    (sa[g]),
            .SRAM_DQ_O (dq[g]),
            .SRAM_DQ_OE(dq_oe[g]),
            .CPU_HOLD  (hold[g]),
            .LOAD_DONE (ld[g]),
            .LOAD_ERR  (le[g]),
            .WORD_COUNT(wcnt[g])
        );
    end

    // Write monitor: one record per WE-low pulse, with bus stability tracked
    initial begin
        lowcnt[0] = 0;
        lowcnt[1] = 0;
    end
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (we_n[k] === 1'b0) begin
                if (lowcnt[k] == 0) begin
                    cap[k].a      = sa[k];
                    cap[k].d      = dq[k];
                    cap[k].stable = (dq_oe[k] === 1'b1);
                end else if (sa[k] !== cap[k].a || dq[k] !== cap[k].d || dq_oe[k] !== 1'b1) begin
                    cap[k].stable = 1'b0;
                end
                lowcnt[k] = lowcnt[k] + 1;
            end else if (lowcnt[k] != 0) begin
                cap[k].len = lowcnt[k];
                if (k == 0) mon0.push_back(cap[k]);
                else        mon1.push_back(cap[k]);
                lowcnt[k] = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(DIV);
        end
        rxd = stop;
        tick(DIV);
        rxd = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        sent_q.push_back(b);
        uart_send(b, 1'b1);
    endtask

    task automatic send_word(input logic [15:0] w, input bit rgap);
        send_byte(w[15:8]);
        if (rgap) tick($urandom_range(0, 30));
        send_byte(w[7:0]);
        if (rgap) tick($urandom_range(0, 30));
    endtask

    task automatic start_load();
        sent_q.delete();
        mon0.delete();
        mon1.delete();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    function automatic int mon_size(input int k);
        return (k == 0) ? mon0.size() : mon1.size();
    endfunction

    function automatic wr_t mon_get(input int k, input int i);
        return (k == 0) ? mon0[i] : mon1[i];
    endfunction

    // Word-level model: pair bytes, write at consecutive addresses, stop on END or MAX
    task automatic verify(input string sc, input int k);
        int          max_w;
        int          nexp;
        bit          done;
        bit          err;
        logic [15:0] w;
        wr_t         r;
        max_w = (k == 0) ? 256 : 2;
        nexp  = 0;
        done  = 0;
        err   = 0;
        for (int i = 0; i + 1 < sent_q.size(); i += 2) begin
            if (done || err) break;
            w = {sent_q[i], sent_q[i+1]};
            if (nexp < mon_size(k)) begin
                r = mon_get(k, nexp);
                check($sformatf("%s_i%0d_w%0d_addr", sc, k, nexp), {14'd0, r.a}, {14'd0, BASE + 18'(nexp)});
                check($sformatf("%s_i%0d_w%0d_data", sc, k, nexp), {16'd0, r.d}, {16'd0, w});
                check($sformatf("%s_i%0d_w%0d_welen", sc, k, nexp), r.len, WEC);
                check($sformatf("%s_i%0d_w%0d_stable", sc, k, nexp), {31'd0, r.stable}, 32'd1);
            end
            nexp++;
            if (w[15:12] == 4'h0) done = 1;
            else if (nexp == max_w) err = 1;
        end
        check($sformatf("%s_i%0d_nwrites", sc, k), mon_size(k), nexp);
        check($sformatf("%s_i%0d_wcount", sc, k), {16'd0, wcnt[k]}, nexp);
        check($sformatf("%s_i%0d_done", sc, k), {31'd0, ld[k]}, {31'd0, done});
        check($sformatf("%s_i%0d_err", sc, k), {31'd0, le[k]}, {31'd0, err});
        check($sformatf("%s_i%0d_hold", sc, k), {31'd0, hold[k]}, {31'd0, !done});
        check($sformatf("%s_i%0d_dqoe", sc, k), {31'd0, dq_oe[k]}, 32'd0);
    endtask

    initial begin
        int          t;
        int          nw;
        logic [15:0] w;

        @(posedge clk);
        #2;
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_i%0d_hold", k), {31'd0, hold[k]}, 32'd0);
            check($sformatf("rst_i%0d_done", k), {31'd0, ld[k]}, 32'd0);
            check($sformatf("rst_i%0d_err", k), {31'd0, le[k]}, 32'd0);
            check($sformatf("rst_i%0d_wcount", k), {16'd0, wcnt[k]}, 32'd0);
            check($sformatf("rst_i%0d_we", k), {31'd0, we_n[k]}, 32'd1);
            check($sformatf("rst_i%0d_oe", k), {31'd0, oe_n[k]}, 32'd0);
            check($sformatf("rst_i%0d_dqoe", k), {31'd0, dq_oe[k]}, 32'd0);
            check($sformatf("rst_i%0d_addr", k), {14'd0, sa[k]}, {14'd0, BASE});
            check($sformatf("rst_i%0d_dq", k), {16'd0, dq[k]}, 32'd0);
            check($sformatf("rst_i%0d_ce_lb_ub", k), {29'd0, ce_n[k], lb_n[k], ub_n[k]}, 32'd0);
        end
        tick(1);
        rst = 1'b0;
        tick(2);

        // Basic load
        start_load();
        send_word(16'h8001, 1'b0);
        send_word(16'h1060, 1'b0);
        send_word(16'h0000, 1'b0);
        tick(20);
        verify("basic", 0);
        verify("basic", 1);
        if (mon0.size() == 3) begin
            check("basic_w0_data", {16'd0, mon0[0].d}, 32'h8001);
            check("basic_w2_addr", {14'd0, mon0[2].a}, 32'h0FF02);
        end

        // Framing error
        start_load();
        uart_send(8'h80, 1'b0);
        tick(12 * DIV);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ferr_i%0d_err", k), {31'd0, le[k]}, 32'd1);
            check($sformatf("ferr_i%0d_hold", k), {31'd0, hold[k]}, 32'd1);
            check($sformatf("ferr_i%0d_nwrites", k), mon_size(k), 0);
        end
        start_load();
        tick(2);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ferr_rearm_i%0d_err", k), {31'd0, le[k]}, 32'd0);
            check($sformatf("ferr_rearm_i%0d_wcount", k), {16'd0, wcnt[k]}, 32'd0);
        end

        // Glitch rejection between the two bytes of a word
        send_byte(8'h80);
        tick(5);
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(3 * DIV);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("glitch_i%0d_nwrites", k), mon_size(k), 0);
            check($sformatf("glitch_i%0d_hold", k), {31'd0, hold[k]}, 32'd1);
            check($sformatf("glitch_i%0d_err", k), {31'd0, le[k]}, 32'd0);
        end
        send_byte(8'h01);
        send_word(16'h0000, 1'b0);
        tick(20);
        verify("glitch", 0);
        verify("glitch", 1);

        // Overflow (instance 1 has MAX_WORDS=2)
        start_load();
        send_word(16'h9000, 1'b1);
        send_word(16'h9001, 1'b1);
        send_word(16'h9002, 1'b1);
        send_word(16'h0000, 1'b1);
        tick(20);
        verify("ovf", 0);
        verify("ovf", 1);

        // Randomized programs
        for (int it = 0; it < 6; it++) begin
            start_load();
            nw = $urandom_range(1, 5);
            for (int j = 0; j < nw; j++) begin
                w = 16'($urandom);
                w[15:12] = 4'($urandom_range(1, 15));
                send_word(w, 1'b1);
            end
            w = 16'($urandom);
            w[15:12] = 4'h0;
            send_word(w, 1'b1);
            tick(20);
            verify($sformatf("rand%0d", it), 0);
            verify($sformatf("rand%0d", it), 1);
        end

        // Reset in the middle of a write pulse
        start_load();
        send_byte(8'h95);
        fork
            uart_send(8'h55, 1'b1);
        join_none
        t = 0;
        while (we_n[0] !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("rstmid_we_low_seen", {31'd0, (t < 400)}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rstmid_i%0d_we", k), {31'd0, we_n[k]}, 32'd1);
            check($sformatf("rstmid_i%0d_dqoe", k), {31'd0, dq_oe[k]}, 32'd0);
            check($sformatf("rstmid_i%0d_hold", k), {31'd0, hold[k]}, 32'd0);
            check($sformatf("rstmid_i%0d_wcount", k), {16'd0, wcnt[k]}, 32'd0);
            check($sformatf("rstmid_i%0d_addr", k), {14'd0, sa[k]}, {14'd0, BASE});
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick(2 * DIV);
        mon0.delete();
        mon1.delete();

        // Bytes in IDLE are ignored
        uart_send(8'h81, 1'b1);
        uart_send(8'h23, 1'b1);
        tick(20);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ign_i%0d_nwrites", k), mon_size(k), 0);
            check($sformatf("ign_i%0d_wcount", k), {16'd0, wcnt[k]}, 32'd0);
            check($sformatf("ign_i%0d_hold", k), {31'd0, hold[k]}, 32'd0);
        end
        start_load();
        send_word(16'h0000, 1'b0);
        tick(20);
        verify("ign", 0);
        verify("ign", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
